// File: rtl/tictac_pkg.sv
// ---------------------------------------------------------------------------
// tictac_pkg
// Shared definitions for the tic-tac-toe move validator:
//   cell_e    : board cell codes (EMPTY / P1 / P2; 2'b11 is never written)
//   reject_e  : response reject codes
//   state_e   : validator FSM states
//   other_player() : the opponent's cell code for a given player code
// ---------------------------------------------------------------------------
package tictac_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10
    } cell_e;

    typedef enum logic [1:0] {
        REJ_NONE     = 2'b00,
        REJ_OCCUPIED = 2'b01,
        REJ_BAD_POS  = 2'b10,
        REJ_FULL     = 2'b11
    } reject_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RESP = 2'b01,
        ST_FULL = 2'b10
    } state_e;

    // Anything that is not P1 hands the move to P1, so a corrupted turn
    // register recovers to a legal player code on the next toggle.
    function automatic logic [1:0] other_player(input logic [1:0] code);
        return (code == CELL_P1) ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// ---------------------------------------------------------------------------
// onehot_decode
// Classifies a W-bit select vector and encodes its set bit.
//   in_i    [W-1:0]        : select vector
//   valid_o                : exactly one bit of in_i is set
//   index_o [clog2(W)-1:0] : position of the set bit (meaningful only when
//                            valid_o is high)
// ---------------------------------------------------------------------------
module onehot_decode #(
    parameter int W = 9
) (
    input  logic [W-1:0]                     in_i,
    output logic                             valid_o,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] index_o
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic seen;
    logic multi;

    // Zero bits leaves seen low; a second set bit raises multi.
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (in_i[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
    end

    assign valid_o = seen & ~multi;

    // Index bit b is the OR of every input whose position has bit b set;
    // exact for a one-hot input.
    for (genvar gb = 0; gb < IW; gb++) begin : g_bit
        logic [W-1:0] sel_mask;
        for (genvar gi = 0; gi < W; gi++) begin : g_cell
            assign sel_mask[gi] = (((gi >> gb) & 1) == 1);
        end
        assign index_o[gb] = |(in_i & sel_mask);
    end

endmodule

// File: rtl/move_validator.sv
// ---------------------------------------------------------------------------
// move_validator
// Checks and commits tic-tac-toe moves on an N x N board. A handshake
// (move_valid & move_ready) is answered by a one-cycle resp_valid pulse on
// the following cycle; accepted moves are already visible on board/turn/
// move_count during that pulse.
//
// Parameters
//   N            : board side length (CELLS = N*N)
//   FIRST_PLAYER : 1 or 2, player to move after reset or new_game
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   new_game     : synchronous clear of the board, highest priority
//   undo         : (only with MOVE_VALIDATOR_UNDO_EN) take back last move
//   move_valid   : move request present
//   move_pos     : one-hot cell select, bit 0 = top-left, row-major
//   move_ready   : request can be accepted this cycle
//   resp_valid   : one-cycle response pulse
//   accept       : move committed (qualified by resp_valid)
//   reject_code  : 00 none, 01 occupied, 10 bad position, 11 board full
//   board        : cell i at bits [2i+1:2i]
//   turn         : cell code of the player to move
//   move_count   : number of occupied cells
// Configuration
//   MOVE_VALIDATOR_UNDO_EN : adds the undo input and a single-level undo
//                            register holding the last accepted cell.
// ---------------------------------------------------------------------------
module move_validator
    import tictac_pkg::*;
#(
    parameter int N            = 3,
    parameter int FIRST_PLAYER = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_game,
`ifdef MOVE_VALIDATOR_UNDO_EN
    input  logic                       undo,
`endif
    input  logic                       move_valid,
    input  logic [N*N-1:0]             move_pos,
    output logic                       move_ready,
    output logic                       resp_valid,
    output logic                       accept,
    output logic [1:0]                 reject_code,
    output logic [2*N*N-1:0]           board,
    output logic [1:0]                 turn,
    output logic [$clog2(N*N+1)-1:0]   move_count
);

    localparam int             CELLS      = N * N;
    localparam int             IW         = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int             CNT_W      = $clog2(CELLS + 1);
    localparam logic [CNT_W-1:0] CELLS_CNT = CNT_W'(CELLS);
    localparam logic [1:0]     FIRST_CODE = (FIRST_PLAYER == 2) ? CELL_P2 : CELL_P1;

    state_e             state_q, state_d;
    logic [2*CELLS-1:0] board_q, board_d;
    logic [1:0]         turn_q, turn_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               resp_valid_q, resp_valid_d;
    logic               accept_q, accept_d;
    logic [1:0]         reject_q, reject_d;

    logic               pos_onehot;
    logic [IW-1:0]      pos_idx;
    logic               pos_occupied;
    logic               handshake;
    logic [CELLS-1:0]   cell_taken;

    onehot_decode #(
        .W (CELLS)
    ) u_decode (
        .in_i    (move_pos),
        .valid_o (pos_onehot),
        .index_o (pos_idx)
    );

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_taken
        assign cell_taken[gi] = |board_q[2*gi +: 2];
    end

    // Only meaningful when move_pos is one-hot: then it reads the one cell.
    assign pos_occupied = |(move_pos & cell_taken);

`ifdef MOVE_VALIDATOR_UNDO_EN
    logic          undo_valid_q, undo_valid_d;
    logic [IW-1:0] undo_idx_q, undo_idx_d;
    logic          undo_fire;

    // An undo that will actually act owns the cycle, so move_ready drops.
    assign undo_fire  = undo & undo_valid_q & (state_q != ST_RESP);
    assign move_ready = (state_q != ST_RESP) & ~undo_fire;
`else
    assign move_ready = (state_q != ST_RESP);
`endif

    assign handshake = move_valid & move_ready;

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        turn_d       = turn_q;
        count_d      = count_q;
        resp_valid_d = 1'b0;
        accept_d     = 1'b0;
        reject_d     = REJ_NONE;
`ifdef MOVE_VALIDATOR_UNDO_EN
        undo_valid_d = undo_valid_q;
        undo_idx_d   = undo_idx_q;
`endif

        case (state_q)
            ST_RESP: begin
                // count_q already includes the move answered this cycle.
                state_d = (count_q == CELLS_CNT) ? ST_FULL : ST_IDLE;
            end
            ST_IDLE, ST_FULL: begin
`ifdef MOVE_VALIDATOR_UNDO_EN
                if (undo_fire) begin
                    for (int i = 0; i < CELLS; i++) begin
                        if (IW'(i) == undo_idx_q) begin
                            board_d[2*i +: 2] = CELL_EMPTY;
                        end
                    end
                    turn_d       = other_player(turn_q);
                    count_d      = count_q - CNT_W'(1);
                    undo_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else
`endif
                if (handshake) begin
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                    if (state_q == ST_FULL) begin
                        reject_d = REJ_FULL;
                    end else if (!pos_onehot) begin
                        reject_d = REJ_BAD_POS;
                    end else if (pos_occupied) begin
                        reject_d = REJ_OCCUPIED;
                    end else begin
                        accept_d = 1'b1;
                        for (int i = 0; i < CELLS; i++) begin
                            if (IW'(i) == pos_idx) begin
                                board_d[2*i +: 2] = turn_q;
                            end
                        end
                        turn_d  = other_player(turn_q);
                        count_d = count_q + CNT_W'(1);
`ifdef MOVE_VALIDATOR_UNDO_EN
                        undo_valid_d = 1'b1;
                        undo_idx_d   = pos_idx;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // new_game overrides everything above, including a response that
        // would otherwise be issued next cycle.
        if (new_game) begin
            state_d      = ST_IDLE;
            board_d      = '0;
            turn_d       = FIRST_CODE;
            count_d      = '0;
            resp_valid_d = 1'b0;
            accept_d     = 1'b0;
            reject_d     = REJ_NONE;
`ifdef MOVE_VALIDATOR_UNDO_EN
            undo_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            board_q      <= '0;
            turn_q       <= FIRST_CODE;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            accept_q     <= 1'b0;
            reject_q     <= REJ_NONE;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            turn_q       <= turn_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            accept_q     <= accept_d;
            reject_q     <= reject_d;
        end
    end

`ifdef MOVE_VALIDATOR_UNDO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            undo_valid_q <= 1'b0;
            undo_idx_q   <= '0;
        end else begin
            undo_valid_q <= undo_valid_d;
            undo_idx_q   <= undo_idx_d;
        end
    end
`endif

    assign resp_valid  = resp_valid_q;
    assign accept      = accept_q;
    assign reject_code = reject_q;
    assign board       = board_q;
    assign turn        = turn_q;
    assign move_count  = count_q;

endmodule

// File: tb/tb_move_validator.sv
// ---------------------------------------------------------------------------
// tb_move_validator
// Self-checking bench for move_validator (N=3, FIRST_PLAYER=1). A game model
// (cell array, current player, move count) predicts each response. Define
// MOVE_VALIDATOR_UNDO_EN for both bench and design to exercise undo.
// ---------------------------------------------------------------------------
module tb_move_validator;

    localparam int CELLS = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_game;
    logic        move_valid;
    logic [8:0]  move_pos;
    logic        move_ready;
    logic        resp_valid;
    logic        accept;
    logic [1:0]  reject_code;
    logic [17:0] board;
    logic [1:0]  turn;
    logic [3:0]  move_count;
`ifdef MOVE_VALIDATOR_UNDO_EN
    logic        undo;
`endif

    int tests = 0;
    int fails = 0;

    // game model
    int m_cell [CELLS];
    int m_turn;
    int m_count;

    // values captured around one transaction
    logic        o_rv, o_acc, o_ready_resp, o_rv_after;
    logic [1:0]  o_code, o_turn;
    logic [17:0] o_board;
    logic [3:0]  o_cnt;

    move_validator #(
        .N            (3),
        .FIRST_PLAYER (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .new_game    (new_game),
`ifdef MOVE_VALIDATOR_UNDO_EN
        .undo        (undo),
`endif
        .move_valid  (move_valid),
        .move_pos    (move_pos),
        .move_ready  (move_ready),
        .resp_valid  (resp_valid),
        .accept      (accept),
        .reject_code (reject_code),
        .board       (board),
        .turn        (turn),
        .move_count  (move_count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < CELLS; i++) m_cell[i] = 0;
        m_turn  = 1;
        m_count = 0;
    endfunction

    function automatic int pos_index(input logic [8:0] p);
        for (int i = 0; i < CELLS; i++) if (p[i]) return i;
        return -1;
    endfunction

    // Expected reject code for a request arriving now: 0 means accept.
    function automatic int model_code(input logic [8:0] p);
        if (m_count == CELLS) return 3;
        if ($countones(p) != 1) return 2;
        if (m_cell[pos_index(p)] != 0) return 1;
        return 0;
    endfunction

    function automatic void model_commit(input logic [8:0] p);
        m_cell[pos_index(p)] = m_turn;
        m_turn  = 3 - m_turn;
        m_count = m_count + 1;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < CELLS; i++) b[2*i +: 2] = 2'(m_cell[i]);
        return b;
    endfunction

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_reset();
        $display("[TB] new_game board=%h count=%0d turn=%b", board, move_count, turn);
    endtask

    // Presents one request, captures the response cycle and the cycle after.
    task automatic apply_move(input logic [8:0] p);
        int waitc;
        waitc = 0;
        while (move_ready !== 1'b1 && waitc < 16) begin
            @(posedge clk); #1;
            waitc++;
        end
        tests++;
        if (move_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_wait: move_ready=%b required 1", move_ready);
        end
        move_valid = 1'b1;
        move_pos   = p;
        @(posedge clk); #1;
        move_valid   = 1'b0;
        move_pos     = '0;
        o_rv         = resp_valid;
        o_acc        = accept;
        o_code       = reject_code;
        o_board      = board;
        o_turn       = turn;
        o_cnt        = move_count;
        o_ready_resp = move_ready;
        @(posedge clk); #1;
        o_rv_after = resp_valid;
        $display("[TB] move pos=%h resp_valid=%b accept=%b code=%b count=%0d turn=%b board=%h",
                 p, o_rv, o_acc, o_code, o_cnt, o_turn, o_board);
    endtask

    task automatic test_reset();
        reset = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_pos = '0;
`ifdef MOVE_VALIDATOR_UNDO_EN
        undo = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        move_valid = 1'b1; move_pos = 9'h001;
        @(posedge clk); #1;
        tests++; if (resp_valid !== 1'b0)   begin fails++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        tests++; if (accept !== 1'b0)       begin fails++; $display("FAIL rst_accept: got %b want 0", accept); end
        tests++; if (reject_code !== 2'b00) begin fails++; $display("FAIL rst_reject: got %b want 00", reject_code); end
        tests++; if (move_ready !== 1'b1)   begin fails++; $display("FAIL rst_ready: got %b want 1", move_ready); end
        tests++; if (board !== 18'h0)       begin fails++; $display("FAIL rst_board: got %h want 0", board); end
        tests++; if (turn !== 2'b01)        begin fails++; $display("FAIL rst_turn: got %b want 01", turn); end
        tests++; if (move_count !== 4'd0)   begin fails++; $display("FAIL rst_count: got %0d want 0", move_count); end
        move_valid = 1'b0; move_pos = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        tests++; if (resp_valid !== 1'b0)   begin fails++; $display("FAIL rst_release_rv: got %b want 0", resp_valid); end
        $display("[TB] reset released ready=%b board=%h", move_ready, board);
    endtask

    task automatic test_first_move();
        apply_move(9'h001);
        model_commit(9'h001);
        tests++; if (o_rv !== 1'b1)        begin fails++; $display("FAIL first_rv: got %b want 1", o_rv); end
        tests++; if (o_acc !== 1'b1)       begin fails++; $display("FAIL first_accept: got %b want 1", o_acc); end
        tests++; if (o_code !== 2'b00)     begin fails++; $display("FAIL first_code: got %b want 00", o_code); end
        tests++; if (o_board !== 18'h1)    begin fails++; $display("FAIL first_board: got %h want 00001", o_board); end
        tests++; if (o_turn !== 2'b10)     begin fails++; $display("FAIL first_turn: got %b want 10", o_turn); end
        tests++; if (o_cnt !== 4'd1)       begin fails++; $display("FAIL first_count: got %0d want 1", o_cnt); end
        tests++; if (o_ready_resp !== 1'b0) begin fails++; $display("FAIL first_ready_resp: got %b want 0", o_ready_resp); end
        tests++; if (o_rv_after !== 1'b0)  begin fails++; $display("FAIL first_rv_after: got %b want 0", o_rv_after); end
        apply_move(9'h001);
        tests++; if (o_rv !== 1'b1)        begin fails++; $display("FAIL repeat_rv: got %b want 1", o_rv); end
        tests++; if (o_acc !== 1'b0)       begin fails++; $display("FAIL repeat_accept: got %b want 0", o_acc); end
        tests++; if (o_code !== 2'b01)     begin fails++; $display("FAIL repeat_code: got %b want 01", o_code); end
        tests++; if (o_board !== 18'h1)    begin fails++; $display("FAIL repeat_board: got %h want 00001", o_board); end
        tests++; if (o_turn !== 2'b10)     begin fails++; $display("FAIL repeat_turn: got %b want 10", o_turn); end
        tests++; if (o_cnt !== 4'd1)       begin fails++; $display("FAIL repeat_count: got %0d want 1", o_cnt); end
    endtask

    task automatic test_bad_position();
        logic [8:0] pats [3];
        pats[0] = 9'h000;
        pats[1] = 9'h003;
        pats[2] = 9'h180 | (9'(1) << $urandom_range(0, 6));
        for (int k = 0; k < 3; k++) begin
            apply_move(pats[k]);
            tests++; if (o_rv !== 1'b1)          begin fails++; $display("FAIL bad_rv[%0d]: got %b want 1", k, o_rv); end
            tests++; if (o_acc !== 1'b0)         begin fails++; $display("FAIL bad_accept[%0d]: got %b want 0", k, o_acc); end
            tests++; if (o_code !== 2'b10)       begin fails++; $display("FAIL bad_code[%0d]: got %b want 10", k, o_code); end
            tests++; if (o_board !== model_board()) begin fails++; $display("FAIL bad_board[%0d]: got %h want %h", k, o_board, model_board()); end
            tests++; if (o_turn !== 2'(m_turn))  begin fails++; $display("FAIL bad_turn[%0d]: got %b want %0d", k, o_turn, m_turn); end
            tests++; if (o_cnt !== 4'(m_count))  begin fails++; $display("FAIL bad_count[%0d]: got %0d want %0d", k, o_cnt, m_count); end
        end
    endtask

    task automatic test_fill_board();
        int         order [CELLS];
        int         j, tmp, ec;
        logic [8:0] p;
        pulse_new_game();
        for (int i = 0; i < CELLS; i++) order[i] = i;
        for (int i = CELLS - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i <= CELLS; i++) begin
            // tenth request goes to a random pattern: a full board rejects anything
            p  = (i < CELLS) ? (9'(1) << order[i]) : 9'($urandom);
            ec = model_code(p);
            if (ec == 0) model_commit(p);
            apply_move(p);
            tests++; if (o_rv !== 1'b1)          begin fails++; $display("FAIL fill_rv[%0d]: got %b want 1", i, o_rv); end
            tests++; if (o_acc !== (ec == 0))    begin fails++; $display("FAIL fill_accept[%0d]: got %b want %0d", i, o_acc, ec == 0); end
            tests++; if (o_code !== 2'(ec))      begin fails++; $display("FAIL fill_code[%0d]: got %b want %0d", i, o_code, ec); end
            tests++; if (o_board !== model_board()) begin fails++; $display("FAIL fill_board[%0d]: got %h want %h", i, o_board, model_board()); end
            tests++; if (o_turn !== 2'(m_turn))  begin fails++; $display("FAIL fill_turn[%0d]: got %b want %0d", i, o_turn, m_turn); end
            tests++; if (o_cnt !== 4'(m_count))  begin fails++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, o_cnt, m_count); end
            tests++; if (o_rv_after !== 1'b0)    begin fails++; $display("FAIL fill_rv_after[%0d]: got %b want 0", i, o_rv_after); end
        end
        tests++; if (reject_code !== 2'b00 && resp_valid === 1'b0) begin fails++; $display("FAIL full_idle_code: got %b want 00", reject_code); end
        pulse_new_game();
        tests++; if (board !== 18'h0)      begin fails++; $display("FAIL ng_board: got %h want 0", board); end
        tests++; if (move_count !== 4'd0)  begin fails++; $display("FAIL ng_count: got %0d want 0", move_count); end
        tests++; if (turn !== 2'b01)       begin fails++; $display("FAIL ng_turn: got %b want 01", turn); end
        tests++; if (move_ready !== 1'b1)  begin fails++; $display("FAIL ng_ready: got %b want 1", move_ready); end
    endtask

    task automatic test_new_game_priority();
        apply_move(9'h020);
        model_commit(9'h020);
        move_valid = 1'b1; move_pos = 9'h004; new_game = 1'b1;
        @(posedge clk); #1;
        move_valid = 1'b0; move_pos = '0; new_game = 1'b0;
        model_reset();
        tests++; if (resp_valid !== 1'b0)  begin fails++; $display("FAIL ngp_rv: got %b want 0", resp_valid); end
        tests++; if (board !== 18'h0)      begin fails++; $display("FAIL ngp_board: got %h want 0", board); end
        tests++; if (move_count !== 4'd0)  begin fails++; $display("FAIL ngp_count: got %0d want 0", move_count); end
        @(posedge clk); #1;
        tests++; if (resp_valid !== 1'b0)  begin fails++; $display("FAIL ngp_rv_late: got %b want 0", resp_valid); end
        $display("[TB] new_game with move board=%h rv=%b", board, resp_valid);
    endtask

    task automatic test_random();
        int         r, ec;
        logic [8:0] p;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_new_game();
            end else begin
                p  = (r <= 6) ? (9'(1) << $urandom_range(0, 8)) : 9'($urandom);
                ec = model_code(p);
                if (ec == 0) model_commit(p);
                apply_move(p);
                tests++; if (o_rv !== 1'b1)          begin fails++; $display("FAIL rnd_rv[%0d]: got %b want 1", it, o_rv); end
                tests++; if (o_acc !== (ec == 0))    begin fails++; $display("FAIL rnd_accept[%0d]: got %b want %0d", it, o_acc, ec == 0); end
                tests++; if (o_code !== 2'(ec))      begin fails++; $display("FAIL rnd_code[%0d]: got %b want %0d", it, o_code, ec); end
                tests++; if (o_board !== model_board()) begin fails++; $display("FAIL rnd_board[%0d]: got %h want %h", it, o_board, model_board()); end
                tests++; if (o_turn !== 2'(m_turn))  begin fails++; $display("FAIL rnd_turn[%0d]: got %b want %0d", it, o_turn, m_turn); end
                tests++; if (o_cnt !== 4'(m_count))  begin fails++; $display("FAIL rnd_count[%0d]: got %0d want %0d", it, o_cnt, m_count); end
                tests++; if (o_ready_resp !== 1'b0)  begin fails++; $display("FAIL rnd_ready_resp[%0d]: got %b want 0", it, o_ready_resp); end
            end
        end
    endtask

    task automatic test_reset_mid_resp();
        pulse_new_game();
        move_valid = 1'b1; move_pos = 9'h100;
        @(posedge clk); #1;
        move_valid = 1'b0; move_pos = '0;
        tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL mid_in_resp: got %b want 1", resp_valid); end
        #2 reset = 1'b0;
        #1;
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_rv: got %b want 0", resp_valid); end
        tests++; if (board !== 18'h0)     begin fails++; $display("FAIL mid_async_board: got %h want 0", board); end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL mid_post_rv[%0d]: got %b want 0", c, resp_valid); end
        end
        tests++; if (board !== 18'h0)      begin fails++; $display("FAIL mid_post_board: got %h want 0", board); end
        tests++; if (move_count !== 4'd0)  begin fails++; $display("FAIL mid_post_count: got %0d want 0", move_count); end
        tests++; if (move_ready !== 1'b1)  begin fails++; $display("FAIL mid_post_ready: got %b want 1", move_ready); end
        $display("[TB] reset during response board=%h rv=%b", board, resp_valid);
    endtask

`ifdef MOVE_VALIDATOR_UNDO_EN
    task automatic test_undo();
        pulse_new_game();
        apply_move(9'h010);
        tests++; if (o_acc !== 1'b1) begin fails++; $display("FAIL undo_setup_accept: got %b want 1", o_acc); end
        // undo and a move request together: undo wins, request not taken
        undo = 1'b1; move_valid = 1'b1; move_pos = 9'h001;
        #1;
        tests++; if (move_ready !== 1'b0) begin fails++; $display("FAIL undo_ready: got %b want 0", move_ready); end
        @(posedge clk); #1;
        undo = 1'b0; move_valid = 1'b0; move_pos = '0;
        tests++; if (resp_valid !== 1'b0)  begin fails++; $display("FAIL undo_rv: got %b want 0", resp_valid); end
        tests++; if (board[9:8] !== 2'b00) begin fails++; $display("FAIL undo_cell4: got %b want 00", board[9:8]); end
        tests++; if (board !== 18'h0)      begin fails++; $display("FAIL undo_board: got %h want 0", board); end
        tests++; if (turn !== 2'b01)       begin fails++; $display("FAIL undo_turn: got %b want 01", turn); end
        tests++; if (move_count !== 4'd0)  begin fails++; $display("FAIL undo_count: got %0d want 0", move_count); end
        $display("[TB] undo board=%h turn=%b count=%0d", board, turn, move_count);
        undo = 1'b1;
        #1;
        tests++; if (move_ready !== 1'b1) begin fails++; $display("FAIL undo2_ready: got %b want 1", move_ready); end
        @(posedge clk); #1;
        undo = 1'b0;
        tests++; if (board !== 18'h0)      begin fails++; $display("FAIL undo2_board: got %h want 0", board); end
        tests++; if (turn !== 2'b01)       begin fails++; $display("FAIL undo2_turn: got %b want 01", turn); end
        tests++; if (move_count !== 4'd0)  begin fails++; $display("FAIL undo2_count: got %0d want 0", move_count); end
        $display("[TB] second undo board=%h turn=%b count=%0d", board, turn, move_count);
        model_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_first_move();
        test_bad_position();
        test_fill_board();
        test_new_game_priority();
        test_random();
        test_reset_mid_resp();
`ifdef MOVE_VALIDATOR_UNDO_EN
        test_undo();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
